// File: rtl/move_cmd_encoder.sv
// Producer of the changeblock move-code bus: key synchronizers, gravity timer, issue/wait FSM.
// Optional Left/Right auto-repeat is built when AUTO_REPEAT_EN is defined.
module move_cmd_encoder #(
   parameter int unsigned GRAV_TICKS   = 25_000_000,
   parameter int unsigned REPEAT_TICKS = 10_000_000,
   parameter int unsigned CW           = 25
) (
   input  logic       CLOCK_50,
   input  logic       Reset,
   input  logic [1:0] mode,
   input  logic       keyLeft,
   input  logic       keyRight,
   input  logic       keyDown,
   input  logic       keyDrop,
   input  logic       cmdAck,
   output logic [3:0] changeblock
);

   localparam logic [3:0] CODE_NOTPLAY   = 4'b0000;
   localparam logic [3:0] CODE_NOTHING   = 4'b0001;
   localparam logic [3:0] CODE_DROP      = 4'b0010;
   localparam logic [3:0] CODE_LEFT      = 4'b0011;
   localparam logic [3:0] CODE_RIGHT     = 4'b0100;
   localparam logic [3:0] CODE_DOWN      = 4'b0101;
   localparam logic [3:0] CODE_LEFTWAIT  = 4'b0111;
   localparam logic [3:0] CODE_RIGHTWAIT = 4'b1000;
   localparam logic [3:0] CODE_DOWNWAIT  = 4'b1001;

   localparam logic [CW-1:0] GRAV_LAST = CW'(GRAV_TICKS - 1);
   localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_TICKS - 1);

   typedef enum logic [3:0] {
      IDLE, ISSUE_L, ISSUE_R, ISSUE_D, ISSUE_X,
      WAIT_L, WAIT_R, WAIT_D, WAIT_X, GRAV
   } state_t;

   state_t          state, state_nxt;
   logic [3:0]      sync1, sync2;
   logic [3:0]      code_nxt;
   logic [CW-1:0]   grav_cnt, grav_cnt_nxt;
   logic            grav_pend, grav_pend_nxt;
   logic            grav_tick, play, enter_dx;
   logic            kl, kr, kd, kx;

   assign kx   = sync2[3];
   assign kd   = sync2[2];
   assign kl   = sync2[1];
   assign kr   = sync2[0];
   assign play = (mode == 2'b01);

`ifdef AUTO_REPEAT_EN
   logic [CW-1:0]   rep_cnt, rep_cnt_nxt;
   logic            rep_done;

   // Counts cycles spent in a Left/Right wait; cleared everywhere else.
   assign rep_cnt_nxt = (state == WAIT_L || state == WAIT_R) ? rep_cnt + 1'b1 : '0;
   assign rep_done    = (rep_cnt == REP_LAST);

   always_ff @(posedge CLOCK_50 or posedge Reset) begin
      if (Reset) rep_cnt <= '0;
      else       rep_cnt <= rep_cnt_nxt;
   end
`else
   logic unused_rep;
   assign unused_rep = ^REP_LAST;
`endif

   function automatic logic [3:0] code_of(input state_t s);
      case (s)
         ISSUE_L: code_of = CODE_LEFT;
         ISSUE_R: code_of = CODE_RIGHT;
         ISSUE_D: code_of = CODE_DOWN;
         ISSUE_X: code_of = CODE_DROP;
         WAIT_L:  code_of = CODE_LEFTWAIT;
         WAIT_R:  code_of = CODE_RIGHTWAIT;
         WAIT_D:  code_of = CODE_DOWNWAIT;
         GRAV:    code_of = CODE_DOWN;
         default: code_of = CODE_NOTHING;
      endcase
   endfunction

   always_ff @(posedge CLOCK_50 or posedge Reset) begin
      if (Reset) begin
         sync1       <= '0;
         sync2       <= '0;
         state       <= IDLE;
         changeblock <= CODE_NOTPLAY;
         grav_cnt    <= '0;
         grav_pend   <= 1'b0;
      end else begin
         sync1       <= {keyDrop, keyDown, keyLeft, keyRight};
         sync2       <= sync1;
         state       <= state_nxt;
         changeblock <= code_nxt;
         grav_cnt    <= grav_cnt_nxt;
         grav_pend   <= grav_pend_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      enter_dx      = 1'b0;
      grav_tick     = play && (grav_cnt == GRAV_LAST);
      grav_cnt_nxt  = grav_tick ? '0 : grav_cnt + 1'b1;
      grav_pend_nxt = grav_pend | grav_tick;

      case (state)
         IDLE: begin
            if (kx) begin
               state_nxt = ISSUE_X;
               enter_dx  = 1'b1;
            end else if (kd) begin
               state_nxt = ISSUE_D;
               enter_dx  = 1'b1;
            end else if (kl)        state_nxt = ISSUE_L;
            else if (kr)            state_nxt = ISSUE_R;
            else if (grav_pend)     state_nxt = GRAV;
         end
         ISSUE_L: if (cmdAck) state_nxt = WAIT_L; else if (!kl) state_nxt = IDLE;
         ISSUE_R: if (cmdAck) state_nxt = WAIT_R; else if (!kr) state_nxt = IDLE;
         ISSUE_D: if (cmdAck) state_nxt = WAIT_D; else if (!kd) state_nxt = IDLE;
         ISSUE_X: if (cmdAck) state_nxt = WAIT_X; else if (!kx) state_nxt = IDLE;
`ifdef AUTO_REPEAT_EN
         WAIT_L: if (!kl) state_nxt = IDLE; else if (rep_done) state_nxt = ISSUE_L;
         WAIT_R: if (!kr) state_nxt = IDLE; else if (rep_done) state_nxt = ISSUE_R;
`else
         WAIT_L: if (!kl) state_nxt = IDLE;
         WAIT_R: if (!kr) state_nxt = IDLE;
`endif
         WAIT_D: if (!kd) state_nxt = IDLE;
         WAIT_X: if (!kx) state_nxt = IDLE;
         GRAV: begin
            // A fresh tick on the ack edge becomes the next pending request.
            if (cmdAck) begin
               state_nxt     = IDLE;
               grav_pend_nxt = grav_tick;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (enter_dx) begin
         grav_cnt_nxt  = '0;
         grav_pend_nxt = 1'b0;
      end

      code_nxt = code_of(state_nxt);

      if (!play) begin
         state_nxt     = IDLE;
         grav_cnt_nxt  = '0;
         grav_pend_nxt = grav_pend;
         code_nxt      = CODE_NOTPLAY;
      end
   end

endmodule

// File: tb/tb_move_cmd_encoder.sv
// Randomized bench for move_cmd_encoder against a cycle-level behavioural model.
module tb_move_cmd_encoder;

   localparam int unsigned G = 8;
   localparam int unsigned R = 4;
`ifdef AUTO_REPEAT_EN
   localparam bit REP_ON = 1'b1;
`else
   localparam bit REP_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] mode;
   logic       kl, kr, kd, kx, ack;
   logic [3:0] cb;

   always #5 clk = ~clk;

   move_cmd_encoder #(.GRAV_TICKS(G), .REPEAT_TICKS(R), .CW(4)) dut (
      .CLOCK_50(clk), .Reset(rst), .mode(mode),
      .keyLeft(kl), .keyRight(kr), .keyDown(kd), .keyDrop(kx),
      .cmdAck(ack), .changeblock(cb)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: key index 0=Drop 1=Down 2=Left 3=Right (also the IDLE priority order).
   // phase 0=idle 1=issuing 2=waiting for release 3=gravity move outstanding.
   logic [3:0] issue_code [4] = '{4'd2, 4'd5, 4'd3, 4'd4};
   logic [3:0] wait_code  [4] = '{4'd1, 4'd9, 4'd7, 4'd8};
   bit         m_k1 [4];
   bit         m_k2 [4];
   int         phase, which, since, wait_age;
   bit         pend;
   logic [3:0] m_out;

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin m_k1[i] = 0; m_k2[i] = 0; end
      phase = 0; which = 0; since = 0; wait_age = 0; pend = 0; m_out = 4'd0;
   endtask

   task automatic model_step();
      bit raw [4];
      bit tick, pend_old;
      int first;
      raw = '{kx, kd, kl, kr};
      if (mode != 2'b01) begin
         phase = 0; since = 0; m_out = 4'd0;
      end else begin
         pend_old = pend;
         tick = (since + 1 == int'(G));
         since = tick ? 0 : since + 1;
         if (tick) pend = 1;
         case (phase)
            0: begin
               first = -1;
               for (int i = 0; i < 4; i++) if (m_k2[i] && first < 0) first = i;
               if (first >= 0) begin
                  phase = 1; which = first;
                  if (first < 2) begin pend = 0; since = 0; end
               end else if (pend_old) phase = 3;
            end
            1: if (ack) begin phase = 2; wait_age = 0; end
               else if (!m_k2[which]) phase = 0;
            2: if (!m_k2[which]) phase = 0;
               else if (REP_ON && which >= 2) begin
                  if (wait_age == int'(R) - 1) phase = 1; else wait_age++;
               end
            default: if (ack) begin phase = 0; if (!tick) pend = 0; end
         endcase
         case (phase)
            0:       m_out = 4'd1;
            1:       m_out = issue_code[which];
            2:       m_out = wait_code[which];
            default: m_out = 4'd5;
         endcase
      end
      m_k2 = m_k1;
      m_k1 = raw;
   endtask

   task automatic run(input int n, input string tag);
      repeat (n) begin
         @(posedge clk);
         if (rst) model_reset(); else model_step();
         @(negedge clk);
         check_eq(tag, cb, m_out);
      end
   endtask

   initial begin
      bit seen;
      rst = 1'b1; mode = 2'b00; kl = 0; kr = 0; kd = 0; kx = 0; ack = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check_eq("reset", cb, 4'd0);
      rst = 1'b0;

      run(20, "notplay");

      // Left: issue, ack, release
      mode = 2'b01; kl = 1;
      run(3, "left_lat");
      check_eq("left_issue", cb, 4'd3);
      run(2, "left_hold");
      ack = 1; run(1, "left_ack_edge"); ack = 0;
      check_eq("left_wait", cb, 4'd7);
      run(2, "left_wait_hold");
      kl = 0;
      run(3, "left_rel");
      check_eq("left_release", cb, 4'd1);

      // Gravity move outstanding, acknowledge it
      run(2, "grav");
      check_eq("grav_out", cb, 4'd5);
      ack = 1; run(1, "grav_ack"); ack = 0;
      check_eq("grav_acked", cb, 4'd1);

      // Drop and Left together: Drop wins
      kx = 1; kl = 1;
      run(3, "drop_left");
      check_eq("drop_prio", cb, 4'd2);
      ack = 1; run(1, "drop_ack"); ack = 0;
      kx = 0; kl = 0;
      run(3, "drop_rel");
      check_eq("drop_idle", cb, 4'd1);
      run(3, "no_left");
      check_eq("no_left_reissue", cb, 4'd1);

      // Right never acked, then released
      kr = 1; run(8, "right_noack"); kr = 0; run(6, "right_rel");

      // Gravity from idle must appear within a bounded window
      seen = 0;
      for (int i = 0; i < 3 * int'(G) && !seen; i++) begin
         run(1, "grav_wait");
         if (cb == 4'd5) seen = 1;
      end
      check_eq("grav_seen", 4'(seen), 4'd1);
      ack = 1; run(1, "grav_ack2"); ack = 0;

      // Left held with every issue acked (repeat behaviour per build)
      kl = 1;
      for (int i = 0; i < 30; i++) begin
         ack = (cb == 4'd3 || cb == 4'd5);
         run(1, "left_repeat");
      end
      ack = 0; kl = 0; run(5, "left_repeat_rel");

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0) kl = ~kl;
         if ($urandom_range(0, 7) == 0) kr = ~kr;
         if ($urandom_range(0, 9) == 0) kd = ~kd;
         if ($urandom_range(0, 11) == 0) kx = ~kx;
         ack = ($urandom_range(0, 3) == 0);
         if (mode == 2'b01) begin
            if ($urandom_range(0, 99) == 0) mode = 2'($urandom_range(0, 3));
         end else if ($urandom_range(0, 3) == 0) mode = 2'b01;
         if ($urandom_range(0, 499) == 0) begin
            #2 rst = 1'b1;
            #1 model_reset();
            check_eq("async_rst", cb, 4'd0);
            @(negedge clk);
            check_eq("rst_hold", cb, 4'd0);
            rst = 1'b0;
         end
         run(1, "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
